// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width, stereo sample pair and transmitter states.
package audio_pkg;

    localparam int AUDIO_SAMPLE_W = 16;

    typedef struct packed {
        logic [AUDIO_SAMPLE_W-1:0] l;
        logic [AUDIO_SAMPLE_W-1:0] r;
    } sample_pair_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/audio_bclk_gen.sv
// Bit-clock generator: toggles bclk every HALF clk cycles while enabled and
// flags the cycle in which the next edge will rise or fall.
module audio_bclk_gen #(
    parameter int HALF = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bclk,
    output logic rise_en,
    output logic fall_en
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] TC = CW'(HALF - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick    = enable && (cnt == TC);
    assign rise_en = tick && !bclk;
    assign fall_en = tick && bclk;

    // Disabled generator parks low so the first edge after enable is a full half-period away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (tick) begin
            cnt  <= '0;
            bclk <= ~bclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: buffers one stereo sample per strobe and serialises it as
// 16-bit left/right words in SLOT_BITS-wide slots, MSB first with one-BCLK delay.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | outputs parked low, waiting for the first sample strobe
// ST_RUN  | BCLK running, one frame per 2*SLOT_BITS bit clocks
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int CLK_RATE   = 24576000,
    parameter int AUDIO_RATE = 48000,
    parameter int SLOT_BITS  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      audio_clk,
    input  logic [AUDIO_SAMPLE_W-1:0] audio_l,
    input  logic [AUDIO_SAMPLE_W-1:0] audio_r,
    output logic                      i2s_bclk,
    output logic                      i2s_lrclk,
    output logic                      i2s_data,
    output logic                      underrun,
    output logic                      overrun
);

    localparam int DIV        = AUDIO_RATE * 2 * SLOT_BITS * 2;
    localparam int HALF       = CLK_RATE / DIV;
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_BITS);

    if (HALF < 1 || HALF * DIV != CLK_RATE) begin : g_bad_rate
        $error("audio_i2s_tx: CLK_RATE must be an exact multiple of 4*AUDIO_RATE*SLOT_BITS");
    end
    if (SLOT_BITS < AUDIO_SAMPLE_W) begin : g_bad_slot
        $error("audio_i2s_tx: SLOT_BITS must hold a full sample");
    end

    function automatic logic [FRAME_BITS-1:0] pack_frame(input sample_pair_t s);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[FRAME_BITS-1 -: AUDIO_SAMPLE_W] = s.l;
        f[SLOT_BITS-1  -: AUDIO_SAMPLE_W] = s.r;
        return f;
    endfunction

    tx_state_t             state;
    sample_pair_t          hold;
    sample_pair_t          last;
    logic                  pending;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  run_en;
    logic                  bclk_fall;
    logic                  bclk_rise_unused;
    logic                  frame_start;

    assign run_en      = (state == ST_RUN);
    assign frame_start = bclk_fall && (bit_cnt == CNT_LAST);
    assign cnt_next    = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;

    audio_bclk_gen #(
        .HALF(HALF)
    ) u_bclk_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (run_en),
        .bclk    (i2s_bclk),
        .rise_en (bclk_rise_unused),
        .fall_en (bclk_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            hold      <= '0;
            last      <= '0;
            pending   <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            i2s_lrclk <= 1'b0;
            i2s_data  <= 1'b0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            // A strobe landing on a frame start replaces a sample that is being consumed, not lost.
            overrun  <= audio_clk && pending && !frame_start;
            if (audio_clk) begin
                hold    <= {audio_l, audio_r};
                pending <= 1'b1;
            end else if (frame_start) begin
                pending <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (audio_clk) begin
                        state   <= ST_RUN;
                        bit_cnt <= CNT_LAST;   // first BCLK fall wraps to 0 and starts a frame
                    end
                end
                ST_RUN: begin
                    if (bclk_fall) begin
                        bit_cnt   <= cnt_next;
                        i2s_lrclk <= (cnt_next >= SLOT_CNT);
                        i2s_data  <= shift_reg[FRAME_BITS-1];
                        if (frame_start) begin
                            if (pending) begin
                                shift_reg <= pack_frame(hold);
                                last      <= hold;
                            end else begin
                                shift_reg <= pack_frame(last);
                                underrun  <= 1'b1;
                            end
                        end else begin
                            shift_reg <= shift_reg << 1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: directed scenarios plus random strobes,
// compared every cycle against an arithmetic timeline model of the I2S stream.
module tb_audio_i2s_tx;

    localparam int HALF  = 4;
    localparam int SLOT  = 32;
    localparam int FRAME = 2 * SLOT;
    localparam int BCLK_P = 2 * HALF;

    logic        clk = 1'b0;
    logic        reset;
    logic        audio_clk;
    logic [15:0] audio_l;
    logic [15:0] audio_r;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_data;
    logic        underrun;
    logic        overrun;

    audio_i2s_tx dut (
        .clk       (clk),
        .reset     (reset),
        .audio_clk (audio_clk),
        .audio_l   (audio_l),
        .audio_r   (audio_r),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_data  (i2s_data),
        .underrun  (underrun),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: m_c counts clk edges since the strobe that left idle; everything
    // else is derived from that timeline and the sample-buffer rules.
    bit          m_run;
    int          m_c;
    bit          m_pend;
    bit          m_under;
    bit          m_over;
    logic [15:0] m_hl, m_hr, m_ll, m_lr, m_cl, m_cr;

    function automatic bit is_fs(input int c);
        return c > 0 && (c % BCLK_P) == 0 && ((c / BCLK_P - 1) % FRAME) == 0;
    endfunction

    function automatic int cur_count();
        int nf;
        nf = m_c / BCLK_P;
        return (!m_run || nf == 0) ? -1 : (nf - 1) % FRAME;
    endfunction

    task automatic model_reset();
        m_run = 0; m_c = 0; m_pend = 0; m_under = 0; m_over = 0;
        m_hl = '0; m_hr = '0; m_ll = '0; m_lr = '0; m_cl = '0; m_cr = '0;
    endtask

    task automatic model_edge(input bit s, input logic [15:0] l, input logic [15:0] r);
        bit fs;
        m_under = 0;
        m_over  = 0;
        if (!m_run) begin
            if (s) begin
                m_run = 1; m_c = 0; m_hl = l; m_hr = r; m_pend = 1;
            end
            return;
        end
        m_c++;
        fs = is_fs(m_c);
        m_over = s && m_pend && !fs;
        if (fs) begin
            if (m_pend) begin
                m_cl = m_hl; m_cr = m_hr; m_ll = m_hl; m_lr = m_hr; m_pend = 0;
            end else begin
                m_cl = m_ll; m_cr = m_lr; m_under = 1;
            end
        end
        if (s) begin
            m_hl = l; m_hr = r; m_pend = 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        bit eb, el, ed;
        int cnt, p;
        eb = 0; el = 0; ed = 0;
        if (m_run) begin
            eb  = ((m_c / HALF) % 2) == 1;
            cnt = cur_count();
            if (cnt >= 0) begin
                el = cnt >= SLOT;
                p  = FRAME - cnt;              // frame bit position on the wire this bit clock
                if (cnt != 0) begin
                    if (p >= FRAME - 16)               ed = m_cl[p - (FRAME - 16)];
                    else if (p >= SLOT - 16 && p < SLOT) ed = m_cr[p - (SLOT - 16)];
                end
            end
        end
        chk({tag, ".bclk"},  i2s_bclk,  eb);
        chk({tag, ".lrclk"}, i2s_lrclk, el);
        chk({tag, ".data"},  i2s_data,  ed);
        chk({tag, ".under"}, underrun,  m_under);
        chk({tag, ".over"},  overrun,   m_over);
    endtask

    task automatic step(input bit s, input logic [15:0] l, input logic [15:0] r);
        audio_clk = s;
        audio_l   = l;
        audio_r   = r;
        @(posedge clk);
        model_edge(s, l, r);
        @(negedge clk);
        check_outputs("cyc");
        audio_clk = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0);
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic seek_frame_start(output bit found);
        found = 0;
        for (int i = 0; i < 4 * FRAME * BCLK_P && !found; i++) begin
            if (m_run && is_fs(m_c + 1)) found = 1;
            else step(1'b0, 16'h0, 16'h0);
        end
    endtask

    initial begin
        bit found;
        int gap;
        reset = 1'b1; audio_clk = 1'b0; audio_l = '0; audio_r = '0;
        model_reset();
        @(negedge clk);
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Long idle: nothing may move before the first strobe.
        idle(10000);

        // Periodic strobes at the nominal sample rate.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 16'h8001, 16'h7FFE);
            idle(FRAME * BCLK_P - 1);
        end

        // Single sample then starvation: repeat and underrun.
        do_reset("rst_a");
        step(1'b1, 16'h1234, 16'hABCD);
        idle(3 * FRAME * BCLK_P);

        // Two strobes 10 clk apart inside one frame: overrun, newest wins.
        do_reset("rst_b");
        step(1'b1, 16'h1111, 16'h2222);
        idle(100);
        step(1'b1, 16'h0001, 16'h0001);
        idle(9);
        step(1'b1, 16'h0002, 16'h0002);
        idle(2 * FRAME * BCLK_P + 50);

        // Strobe coincident with a frame start.
        do_reset("rst_c");
        step(1'b1, 16'hA5A5, 16'h5A5A);
        idle(100);
        step(1'b1, 16'hC3C3, 16'h3C3C);
        seek_frame_start(found);
        chk("seek_fs", found, 1'b1);
        step(1'b1, 16'h0F0F, 16'hF0F0);
        idle(2 * FRAME * BCLK_P + 50);

        // Reset in the middle of a frame at bit 40.
        do_reset("rst_d");
        step(1'b1, 16'hBEEF, 16'hCAFE);
        found = 0;
        for (int i = 0; i < 2 * FRAME * BCLK_P && !found; i++) begin
            if (cur_count() == 40 && (m_c % BCLK_P) == 0) found = 1;
            else step(1'b0, 16'h0, 16'h0);
        end
        chk("seek_bit40", found, 1'b1);
        do_reset("rst_bit40");
        idle(300);
        step(1'b1, 16'h7777, 16'h8888);
        idle(FRAME * BCLK_P + 20);

        // Random strobe spacing and data, mostly near the frame rate with occasional bursts.
        gap = 0;
        for (int i = 0; i < 25000; i++) begin
            if (gap == 0) begin
                step(1'b1, 16'($urandom), 16'($urandom));
                gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 40))
                                                 : int'($urandom_range(400, 650));
            end else begin
                step(1'b0, 16'h0, 16'h0);
                gap--;
            end
            if (i == 12000) do_reset("rst_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
